// File: rtl/button_pkg.sv
// Shared state encoding, counter geometry and default tick constants for the button press generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package button_pkg;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] CNT_MAX = 6'h3F;

    localparam int DEF_SHORT_TICKS = 13;
    localparam int DEF_LONG_TICKS  = 40;
    localparam int DEF_GAP_TICKS   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS_S = 2'd1,
        ST_PRESS_L = 2'd2,
        ST_GAP     = 2'd3
    } btn_state_e;

    // True while the emulated button is held down.
    function automatic logic is_press(input btn_state_e st);
        return (st == ST_PRESS_S) || (st == ST_PRESS_L);
    endfunction

endpackage

// File: rtl/button_tick_counter.sv
// 6-bit strobe counter with clear, enable, saturation at 63 and a terminal-match flag.
// Latency: count updates one edge after en_i; hit_o is combinational on the current count.
// Backpressure: none; clear has priority over enable.
module button_tick_counter
    import button_pkg::*;
(
    input  logic             SlowClock,
    input  logic             MainReset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   inc;

    assign inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // hit_o flags the strobe that brings the count to the terminal value; it
    // deliberately ignores clr_i so the FSM can use it without a feedback loop.
    assign hit_o = en_i && (inc == {1'b0, term_i});

    // Next count: clear wins, otherwise count enabled strobes and hold at the top.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = inc[CNT_W-1:0];
        end
    end

    // Count register.
    always_ff @(posedge SlowClock or negedge MainReset) begin
        if (!MainReset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_press_gen.sv
// Emulates a chipset power button: timed short press, optional long (override) press, then a released gap.
// Latency: ButtonOut falls one SlowClock edge after an accepted request; Done pulses on return to idle.
// Backpressure: requests outside idle are dropped, never queued. Long press built only with BUTTON_LONG_PRESS_EN.
module button_press_gen
    import button_pkg::*;
#(
    parameter int SHORT_TICKS = DEF_SHORT_TICKS,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int GAP_TICKS   = DEF_GAP_TICKS
) (
    input  logic SlowClock,
    input  logic MainReset,
    input  logic Strobe16ms,
    input  logic Strobe125ms,
    input  logic ShortReq,
    input  logic LongReq,
    input  logic Abort,
    output logic ButtonOut,
    output logic Busy,
    output logic Done
);

    btn_state_e       state_q;
    btn_state_e       state_d;
    logic             button_q;
    logic             button_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             tick_en;
    logic             tick_clr;
    logic             tick_hit;
    logic [CNT_W-1:0] tick_term;

`ifndef BUTTON_LONG_PRESS_EN
    // Without the long-press feature the request line is tied off on purpose.
    logic unused_long_req;
    assign unused_long_req = LongReq;
`endif

    // Pick which strobe advances the counter and the terminal count for the current state.
    always_comb begin
        tick_en   = 1'b0;
        tick_term = CNT_W'(GAP_TICKS);
        case (state_q)
            ST_PRESS_S: begin
                tick_en   = Strobe16ms;
                tick_term = CNT_W'(SHORT_TICKS);
            end
            ST_PRESS_L: begin
                tick_en   = Strobe125ms;
                tick_term = CNT_W'(LONG_TICKS);
            end
            ST_GAP: begin
                tick_en   = Strobe16ms;
                tick_term = CNT_W'(GAP_TICKS);
            end
            default: begin
                tick_en   = 1'b0;
                tick_term = CNT_W'(GAP_TICKS);
            end
        endcase
    end

    // Every state change restarts the count, so a strobe on the entry edge is never counted.
    assign tick_clr = (state_d != state_q);

    button_tick_counter u_tick (
        .SlowClock (SlowClock),
        .MainReset (MainReset),
        .clr_i     (tick_clr),
        .en_i      (tick_en),
        .term_i    (tick_term),
        .hit_o     (tick_hit)
    );

    // Next-state decision and registered-output precompute.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
`ifdef BUTTON_LONG_PRESS_EN
                if (LongReq) begin
                    state_d = ST_PRESS_L;
                end else if (ShortReq) begin
                    state_d = ST_PRESS_S;
                end
`else
                if (ShortReq) begin
                    state_d = ST_PRESS_S;
                end
`endif
            end
            ST_PRESS_S: begin
                if (Abort || tick_hit) begin
                    state_d = ST_GAP;
                end
            end
            ST_PRESS_L: begin
`ifdef BUTTON_LONG_PRESS_EN
                if (Abort || tick_hit) begin
                    state_d = ST_GAP;
                end
`else
                // Unreachable in this build; recover to idle if ever seen.
                state_d = ST_IDLE;
`endif
            end
            ST_GAP: begin
                if (tick_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        button_d = !is_press(state_d);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_GAP) && (state_d == ST_IDLE);
    end

    // State and output registers; reset releases the button at once.
    always_ff @(posedge SlowClock or negedge MainReset) begin
        if (!MainReset) begin
            state_q  <= ST_IDLE;
            button_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            button_q <= button_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ButtonOut = button_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_button_press_gen.sv
// Directed bench for button_press_gen with default tick constants (13 / 40 / 4).
// Latency: inputs driven 1 time unit after the rising edge, outputs checked 1 unit after the next edge.
// Backpressure: n/a; long-press scenarios run only when BUTTON_LONG_PRESS_EN is defined.
module tb_button_press_gen;

    logic SlowClock;
    logic MainReset;
    logic Strobe16ms;
    logic Strobe125ms;
    logic ShortReq;
    logic LongReq;
    logic Abort;
    logic ButtonOut;
    logic Busy;
    logic Done;

    int errors;
    int checks;
    int done_cnt;

    button_press_gen #(
        .SHORT_TICKS (13),
        .LONG_TICKS  (40),
        .GAP_TICKS   (4)
    ) dut (
        .SlowClock   (SlowClock),
        .MainReset   (MainReset),
        .Strobe16ms  (Strobe16ms),
        .Strobe125ms (Strobe125ms),
        .ShortReq    (ShortReq),
        .LongReq     (LongReq),
        .Abort       (Abort),
        .ButtonOut   (ButtonOut),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial SlowClock = 1'b0;
    always #5 SlowClock = ~SlowClock;

    // Count every Done cycle independently of the scenario tasks.
    always @(negedge SlowClock) begin
        if (Done === 1'b1) done_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge SlowClock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // n single-cycle Strobe16ms pulses, each followed by one quiet cycle.
    task automatic strobes16(input int n);
        for (int i = 0; i < n; i++) begin
            Strobe16ms = 1'b1;
            tick();
            Strobe16ms = 1'b0;
            tick();
        end
    endtask

    task automatic strobes125(input int n);
        for (int i = 0; i < n; i++) begin
            Strobe125ms = 1'b1;
            tick();
            Strobe125ms = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        MainReset   = 1'b0;
        Strobe16ms  = 1'b0;
        Strobe125ms = 1'b0;
        ShortReq    = 1'b0;
        LongReq     = 1'b0;
        Abort       = 1'b0;
        ticks(3);
        checks++;
        if ({ButtonOut, Busy, Done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_outputs: got {btn,busy,done}=%b want 100", {ButtonOut, Busy, Done});
        end
        MainReset = 1'b1;
        ticks(2);
        // Strobes and Abort in idle must not start anything.
        Abort = 1'b1;
        strobes16(2);
        strobes125(2);
        Abort = 1'b0;
        checks++;
        if ({ButtonOut, Busy, Done} !== 3'b100) begin
            errors++;
            $display("FAIL idle_quiet: got {btn,busy,done}=%b want 100", {ButtonOut, Busy, Done});
        end
    endtask

    task automatic test_short();
        int d0;
        d0 = done_cnt;
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        checks++;
        if ({ButtonOut, Busy} !== 2'b01) begin
            errors++;
            $display("FAIL short_start: got {btn,busy}=%b want 01", {ButtonOut, Busy});
        end
        strobes16(12);
        checks++;
        if (ButtonOut !== 1'b0) begin
            errors++;
            $display("FAIL short_held_12: got btn=%b want 0", ButtonOut);
        end
        Strobe16ms = 1'b1;
        tick();
        Strobe16ms = 1'b0;
        checks++;
        if ({ButtonOut, Busy, Done} !== 3'b110) begin
            errors++;
            $display("FAIL short_release_13: got {btn,busy,done}=%b want 110", {ButtonOut, Busy, Done});
        end
        tick();
        strobes16(3);
        checks++;
        if ({Busy, Done} !== 2'b10 || done_cnt != d0) begin
            errors++;
            $display("FAIL short_gap_3: got {busy,done}=%b dones=%0d want 10 dones=%0d", {Busy, Done}, done_cnt, d0);
        end
        Strobe16ms = 1'b1;
        tick();
        Strobe16ms = 1'b0;
        checks++;
        if ({ButtonOut, Busy, Done} !== 3'b101) begin
            errors++;
            $display("FAIL short_done: got {btn,busy,done}=%b want 101", {ButtonOut, Busy, Done});
        end
        tick();
        checks++;
        if (Done !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL short_done_width: got done=%b dones=%0d want 0 dones=%0d", Done, done_cnt, d0 + 1);
        end
    endtask

    task automatic test_ignore_requests();
        int d0;
        d0 = done_cnt;
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        strobes16(5);
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        strobes16(7);
        checks++;
        if (ButtonOut !== 1'b0) begin
            errors++;
            $display("FAIL ignore_held_12: got btn=%b want 0", ButtonOut);
        end
        strobes16(1);
        checks++;
        if ({ButtonOut, Busy} !== 2'b11) begin
            errors++;
            $display("FAIL ignore_release_13: got {btn,busy}=%b want 11", {ButtonOut, Busy});
        end
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        strobes16(4);
        ticks(30);
        checks++;
        if ({ButtonOut, Busy} !== 2'b10 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL ignore_one_done: got {btn,busy}=%b dones=%0d want 10 dones=%0d", {ButtonOut, Busy}, done_cnt - d0, 1);
        end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        strobes16(5);
        Abort = 1'b1;
        tick();
        checks++;
        if ({ButtonOut, Busy} !== 2'b11) begin
            errors++;
            $display("FAIL abort_release: got {btn,busy}=%b want 11", {ButtonOut, Busy});
        end
        // Abort stays high through the gap: it must not shorten or extend it.
        strobes16(3);
        checks++;
        if (Busy !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL abort_gap_3: got busy=%b dones=%0d want 1 dones=%0d", Busy, done_cnt, d0);
        end
        Strobe16ms = 1'b1;
        tick();
        Strobe16ms = 1'b0;
        Abort = 1'b0;
        checks++;
        if ({Busy, Done} !== 2'b01) begin
            errors++;
            $display("FAIL abort_done: got {busy,done}=%b want 01", {Busy, Done});
        end
    endtask

    task automatic test_back_to_back();
        // Entered in the Done cycle left by test_abort; request in the cycle after.
        tick();
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        checks++;
        if ({ButtonOut, Busy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_accept: got {btn,busy}=%b want 01", {ButtonOut, Busy});
        end
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        strobes16(4);
        tick();
        checks++;
        if ({ButtonOut, Busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_finish: got {btn,busy}=%b want 10", {ButtonOut, Busy});
        end
    endtask

    task automatic test_reset_mid_short();
        int d0;
        d0 = done_cnt;
        ShortReq = 1'b1;
        tick();
        ShortReq = 1'b0;
        strobes16(3);
        MainReset = 1'b0;
        #1;
        checks++;
        if ({ButtonOut, Busy, Done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid_short: got {btn,busy,done}=%b want 100", {ButtonOut, Busy, Done});
        end
        ticks(2);
        MainReset = 1'b1;
        strobes16(15);
        checks++;
        if ({ButtonOut, Busy} !== 2'b10 || done_cnt != d0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got {btn,busy}=%b dones=%0d want 10 dones=%0d", {ButtonOut, Busy}, done_cnt, d0);
        end
    endtask

`ifdef BUTTON_LONG_PRESS_EN
    task automatic test_long_priority();
        int d0;
        d0 = done_cnt;
        ShortReq = 1'b1;
        LongReq  = 1'b1;
        tick();
        ShortReq = 1'b0;
        LongReq  = 1'b0;
        // Short-press strobes must not end a long press.
        strobes16(20);
        strobes125(39);
        checks++;
        if ({ButtonOut, Busy} !== 2'b01) begin
            errors++;
            $display("FAIL long_held_39: got {btn,busy}=%b want 01", {ButtonOut, Busy});
        end
        Strobe125ms = 1'b1;
        tick();
        Strobe125ms = 1'b0;
        checks++;
        if ({ButtonOut, Busy} !== 2'b11) begin
            errors++;
            $display("FAIL long_release_40: got {btn,busy}=%b want 11", {ButtonOut, Busy});
        end
        tick();
        strobes16(4);
        checks++;
        if (Busy !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL long_done: got busy=%b dones=%0d want 0 dones=%0d", Busy, done_cnt, d0 + 1);
        end
    endtask

    task automatic test_long_reset();
        int d0;
        d0 = done_cnt;
        LongReq = 1'b1;
        tick();
        LongReq = 1'b0;
        strobes125(20);
        checks++;
        if (ButtonOut !== 1'b0) begin
            errors++;
            $display("FAIL long_reset_pre: got btn=%b want 0", ButtonOut);
        end
        MainReset = 1'b0;
        #1;
        checks++;
        if ({ButtonOut, Busy, Done} !== 3'b100) begin
            errors++;
            $display("FAIL long_reset_now: got {btn,busy,done}=%b want 100", {ButtonOut, Busy, Done});
        end
        ticks(2);
        MainReset = 1'b1;
        strobes16(6);
        strobes125(25);
        checks++;
        if ({ButtonOut, Busy} !== 2'b10 || done_cnt != d0) begin
            errors++;
            $display("FAIL long_reset_quiet: got {btn,busy}=%b dones=%0d want 10 dones=%0d", {ButtonOut, Busy}, done_cnt, d0);
        end
    endtask
`else
    task automatic test_long_disabled();
        LongReq = 1'b1;
        tick();
        LongReq = 1'b0;
        checks++;
        if ({ButtonOut, Busy} !== 2'b10) begin
            errors++;
            $display("FAIL nolong_ignored: got {btn,busy}=%b want 10", {ButtonOut, Busy});
        end
        strobes125(3);
        checks++;
        if ({ButtonOut, Busy} !== 2'b10) begin
            errors++;
            $display("FAIL nolong_quiet: got {btn,busy}=%b want 10", {ButtonOut, Busy});
        end
        // Both requests together: ShortReq alone decides, so a short press follows.
        ShortReq = 1'b1;
        LongReq  = 1'b1;
        tick();
        ShortReq = 1'b0;
        LongReq  = 1'b0;
        strobes16(12);
        checks++;
        if (ButtonOut !== 1'b0) begin
            errors++;
            $display("FAIL nolong_both_held: got btn=%b want 0", ButtonOut);
        end
        strobes16(1);
        checks++;
        if ({ButtonOut, Busy} !== 2'b11) begin
            errors++;
            $display("FAIL nolong_both_short: got {btn,busy}=%b want 11", {ButtonOut, Busy});
        end
        strobes16(4);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL nolong_both_done: got busy=%b want 0", Busy);
        end
    endtask
`endif

    initial begin
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        test_reset();
        test_short();
        test_ignore_requests();
        test_abort();
        test_back_to_back();
        test_reset_mid_short();
`ifdef BUTTON_LONG_PRESS_EN
        test_long_priority();
        test_long_reset();
`else
        test_long_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
